// File: rtl/level_guess_engine.sv
// Per-level guess engine: collects a keypad guess, compares it one slot per cycle
// against a secret latched at level start, and tracks wrong guesses and done/fail.
module level_guess_engine #(
    parameter int CODE_LEN  = 4,
    parameter int SYM_W     = 4,
    parameter int MAX_WRONG = 3
) (
    input  logic                      Clk_i,
    input  logic                      reset_i,
    input  logic                      levelStart_i,
    input  logic [CODE_LEN*SYM_W-1:0] secret_i,
    input  logic                      keyValid_i,
    input  logic [SYM_W-1:0]          keyCode_i,
    input  logic                      keyEnter_i,
    input  logic                      keyBack_i,
    output logic [CODE_LEN*SYM_W-1:0] entry_o,
    output logic [2:0]                entryCount_o,
    output logic [2:0]                lastMatch_o,
    output logic [2:0]                guesses_o,
    output logic                      levelDone_o,
    output logic                      levelFail_o,
    output logic                      busy_o
);

    localparam logic [2:0] LEN  = 3'(CODE_LEN);
    localparam logic [2:0] LAST = 3'(CODE_LEN - 1);
    localparam logic [3:0] MAXW = 4'(MAX_WRONG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_RESULT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t                    state_q, state_d;
    logic [CODE_LEN*SYM_W-1:0] secret_q, secret_d;
    logic [CODE_LEN*SYM_W-1:0] entry_q, entry_d;
    logic [2:0]                count_q, count_d;
    logic [2:0]                idx_q, idx_d;
    logic [2:0]                match_q, match_d;
    logic [2:0]                last_match_q, last_match_d;
    logic [2:0]                guesses_q, guesses_d;
    logic                      done_q, done_d;
    logic                      fail_q, fail_d;
    logic                      slot_eq;
    logic [3:0]                guess_inc;

    always_ff @(posedge Clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            secret_q     <= '0;
            entry_q      <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            match_q      <= '0;
            last_match_q <= '0;
            guesses_q    <= '0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            secret_q     <= secret_d;
            entry_q      <= entry_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            match_q      <= match_d;
            last_match_q <= last_match_d;
            guesses_q    <= guesses_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
        end
    end

    always_comb begin
        slot_eq = 1'b0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (3'(i) == idx_q)
                slot_eq = (entry_q[i*SYM_W +: SYM_W] == secret_q[i*SYM_W +: SYM_W]);
        end
    end

    // Widened so the fail threshold compare is correct even when guesses is saturated.
    assign guess_inc = {1'b0, guesses_q} + 4'd1;

    always_comb begin
        state_d      = state_q;
        secret_d     = secret_q;
        entry_d      = entry_q;
        count_d      = count_q;
        idx_d        = idx_q;
        match_d      = match_q;
        last_match_d = last_match_q;
        guesses_d    = guesses_q;
        done_d       = done_q;
        fail_d       = fail_q;

        if (state_q != S_IDLE && !levelStart_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (levelStart_i) begin
                        secret_d     = secret_i;
                        guesses_d    = '0;
                        last_match_d = '0;
                        entry_d      = '0;
                        count_d      = '0;
                        done_d       = 1'b0;
                        fail_d       = 1'b0;
                        state_d      = S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (keyValid_i) begin
                        if (keyEnter_i) begin
                            if (count_q == LEN) begin
                                idx_d   = '0;
                                match_d = '0;
                                state_d = S_CHECK;
                            end
                        end else if (keyBack_i) begin
                            if (count_q != 3'd0)
                                count_d = count_q - 3'd1;
                        end else if (count_q < LEN) begin
                            for (int i = 0; i < CODE_LEN; i++) begin
                                if (3'(i) == count_q)
                                    entry_d[i*SYM_W +: SYM_W] = keyCode_i;
                            end
                            count_d = count_q + 3'd1;
                        end
                    end
                end
                S_CHECK: begin
                    match_d = match_q + {2'b00, slot_eq};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == LAST)
                        state_d = S_RESULT;
                end
                S_RESULT: begin
                    last_match_d = match_q;
                    if (match_q == LEN) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        guesses_d = (guesses_q == 3'd7) ? 3'd7 : guesses_q + 3'd1;
                        count_d   = '0;
                        if (guess_inc >= MAXW) begin
                            fail_d  = 1'b1;
                            state_d = S_FAIL;
                        end else begin
                            state_d = S_ENTRY;
                        end
                    end
                end
                S_DONE:  state_d = S_DONE;
                S_FAIL:  state_d = S_FAIL;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign entry_o      = entry_q;
    assign entryCount_o = count_q;
    assign lastMatch_o  = last_match_q;
    assign guesses_o    = guesses_q;
    assign levelDone_o  = done_q;
    assign levelFail_o  = fail_q;
    assign busy_o       = (state_q == S_CHECK) || (state_q == S_RESULT);

endmodule
